// File: rtl/rand_range_sampler.sv
`default_nettype none
// ============================================================================
// Module   : rand_range_sampler
// Purpose  : Turns a free-running 16-bit LFSR stream into a uniform value in
//            [0, range_i) using mask-and-reject sampling, with a bounded
//            retry count, a fold-back fallback and optional no-repeat rule.
//            Results are delivered over a valid/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rand_range_sampler #(
  parameter int OUT_W     = 8,
  parameter int MAX_TRIES = 16,
  parameter bit NO_REPEAT = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [15:0]                      rand_num,
  input  logic                             req,
  input  logic [OUT_W-1:0]                 range_i,
  input  logic                             ack,
  output logic [OUT_W-1:0]                 value_o,
  output logic                             valid_o,
  output logic                             busy_o,
  output logic                             fallback_o,
  output logic                             err_o,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_o
);

  localparam int                  c_TW       = $clog2(MAX_TRIES + 1);
  localparam logic [OUT_W-1:0]    c_ONE      = OUT_W'(1);
  localparam logic [c_TW-1:0]     c_LAST_TRY = c_TW'(MAX_TRIES - 1);
  localparam logic [c_TW-1:0]     c_MAX      = c_TW'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_last_valid;
  logic [OUT_W-1:0]   r_last_value;
  logic [OUT_W-1:0]   r_range_q;
  logic [OUT_W-1:0]   r_mask_q;

  logic [OUT_W-1:0]   w_range_m1;
  logic [OUT_W-1:0]   w_mask_next;
  logic [OUT_W-1:0]   w_cand;
  logic               w_rep_guard;
  logic               w_ok;
  logic [OUT_W-1:0]   w_wrap;
  logic [OUT_W-1:0]   w_fb;

  // Upper LFSR bits are not needed when OUT_W is narrower than the stream.
  generate
    if (OUT_W < 16) begin : g_unused_rand
      logic w_unused_rand;
      assign w_unused_rand = ^rand_num[15:OUT_W];
    end
  endgenerate

  // Smear the highest set bit of (range-1) downward to get the 2^k-1 mask.
  always_comb begin
    w_range_m1  = range_i - c_ONE;
    w_mask_next = w_range_m1;
    for (int s = 1; s < OUT_W; s = s * 2) begin
      w_mask_next = w_mask_next | (w_mask_next >> s);
    end
  end

  // Candidate acceptance and fold-back fallback; cand < 2*range so a single
  // subtraction always lands inside the range.
  always_comb begin
    w_cand      = rand_num[OUT_W-1:0] & r_mask_q;
    w_rep_guard = NO_REPEAT && r_last_valid && (r_range_q > c_ONE);
    w_ok        = (w_cand < r_range_q) && !(w_rep_guard && (w_cand == r_last_value));
    w_wrap      = (w_cand >= r_range_q) ? (w_cand - r_range_q) : w_cand;
    w_fb        = w_wrap;
    if (w_rep_guard && (w_wrap == r_last_value)) begin
      w_fb = (w_wrap == (r_range_q - c_ONE)) ? '0 : (w_wrap + c_ONE);
    end
  end

  // Control FSM with all handshake outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      value_o      <= '0;
      valid_o      <= 1'b0;
      busy_o       <= 1'b0;
      fallback_o   <= 1'b0;
      err_o        <= 1'b0;
      tries_o      <= '0;
      r_last_valid <= 1'b0;
      r_last_value <= '0;
      r_range_q    <= '0;
      r_mask_q     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            busy_o <= 1'b1;
            if (range_i == '0) begin
              value_o    <= '0;
              err_o      <= 1'b1;
              fallback_o <= 1'b0;
              tries_o    <= '0;
              valid_o    <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_range_q  <= range_i;
              r_mask_q   <= w_mask_next;
              tries_o    <= '0;
              fallback_o <= 1'b0;
              err_o      <= 1'b0;
              r_state    <= S_SAMPLE;
            end
          end
        end

        S_SAMPLE: begin
          if (w_ok) begin
            value_o <= w_cand;
            valid_o <= 1'b1;
            r_state <= S_DONE;
          end else if (tries_o == c_LAST_TRY) begin
            value_o    <= w_fb;
            fallback_o <= 1'b1;
            tries_o    <= c_MAX;
            valid_o    <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            tries_o <= tries_o + 1'b1;
          end
        end

        S_DONE: begin
          if (ack) begin
            r_last_value <= value_o;
            r_last_valid <= !err_o;
            valid_o      <= 1'b0;
            busy_o       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rand_range_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rand_range_sampler
// Purpose  : Directed scoreboard bench for rand_range_sampler. Instance 0 is
//            the default configuration, instance 1 has NO_REPEAT=0, and
//            instance 2 has MAX_TRIES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rand_range_sampler;

  typedef struct {
    int value;
    int fb;
    int err;
    int tries;
    int lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst      [3];
  logic        req      [3];
  logic        ack      [3];
  logic [15:0] rand_num [3];
  logic [7:0]  range_i  [3];
  logic [7:0]  value    [3];
  logic        valid    [3];
  logic        busy     [3];
  logic        fb       [3];
  logic        err      [3];
  logic [4:0]  tries0, tries1;
  logic [2:0]  tries2;

  exp_t        q [3][$];
  logic [15:0] rq [$];
  int          cyc  [3] = '{-1, -1, -1};
  int          pv   [3] = '{0, 0, 0};
  int          held [3] = '{0, 0, 0};
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  rand_range_sampler #(.OUT_W(8), .MAX_TRIES(16), .NO_REPEAT(1'b1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .rand_num(rand_num[0]), .req(req[0]), .range_i(range_i[0]),
    .ack(ack[0]), .value_o(value[0]), .valid_o(valid[0]), .busy_o(busy[0]),
    .fallback_o(fb[0]), .err_o(err[0]), .tries_o(tries0));

  rand_range_sampler #(.OUT_W(8), .MAX_TRIES(16), .NO_REPEAT(1'b0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .rand_num(rand_num[1]), .req(req[1]), .range_i(range_i[1]),
    .ack(ack[1]), .value_o(value[1]), .valid_o(valid[1]), .busy_o(busy[1]),
    .fallback_o(fb[1]), .err_o(err[1]), .tries_o(tries1));

  rand_range_sampler #(.OUT_W(8), .MAX_TRIES(4), .NO_REPEAT(1'b1)) u_dut2 (
    .clk(clk), .rst(rst[2]), .rand_num(rand_num[2]), .req(req[2]), .range_i(range_i[2]),
    .ack(ack[2]), .value_o(value[2]), .valid_o(valid[2]), .busy_o(busy[2]),
    .fallback_o(fb[2]), .err_o(err[2]), .tries_o(tries2));

  function automatic int get_tries(int d);
    if (d == 0) return int'(tries0);
    if (d == 1) return int'(tries1);
    return int'(tries2);
  endfunction

  function automatic exp_t mk(int v, int f, int e, int t, int l);
    exp_t r;
    r.value = v; r.fb = f; r.err = e; r.tries = t; r.lat = l;
    return r;
  endfunction

  task automatic chk(string nm, int d, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[dut%0d]: got %0d expected %0d at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard when a result appears and checks it is held.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rst[d]) begin
        cyc[d] = -1;
        pv[d]  = 0;
      end else begin
        if (cyc[d] >= 0) cyc[d]++;
        else if (req[d] && !busy[d] && !valid[d]) cyc[d] = 0;
        if (valid[d] && pv[d] == 0) begin
          if (q[d].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result[dut%0d]: got value %0d expected no result", d, value[d]);
          end else begin
            e = q[d].pop_front();
            chk("value",    d, int'(value[d]), e.value);
            chk("fallback", d, int'(fb[d]),    e.fb);
            chk("err",      d, int'(err[d]),   e.err);
            chk("tries",    d, get_tries(d),   e.tries);
            chk("latency",  d, cyc[d],         e.lat);
            held[d] = e.value;
          end
          cyc[d] = -1;
        end else if (valid[d]) begin
          chk("value_hold", d, int'(value[d]), held[d]);
        end
        pv[d] = valid[d] ? 1 : 0;
      end
    end
  end

  // Issue one request; rq supplies rand_num for each SAMPLE edge in turn.
  task automatic go(int d, int rng, exp_t e);
    q[d].push_back(e);
    @(posedge clk); #1;
    req[d]     = 1'b1;
    range_i[d] = 8'(rng);
    if (rq.size() > 0) rand_num[d] = rq[0];
    @(posedge clk); #1;
    req[d] = 1'b0;
    foreach (rq[i]) begin
      rand_num[d] = rq[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_ack(int d, int hold);
    int t = 0;
    while (!valid[d] && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (!valid[d]) begin
      n_vec++;
      n_err++;
      $display("FAIL valid_timeout[dut%0d]: got valid 0 expected 1", d);
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    ack[d] = 1'b1;
    @(posedge clk); #1;
    ack[d] = 1'b0;
    chk("busy_after_ack",  d, int'(busy[d]),  0);
    chk("valid_after_ack", d, int'(valid[d]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; ack[d] = 1'b0;
      rand_num[d] = 16'h0000; range_i[d] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("rst_value", d, int'(value[d]), 0);
      chk("rst_valid", d, int'(valid[d]), 0);
      chk("rst_busy",  d, int'(busy[d]),  0);
      chk("rst_fb",    d, int'(fb[d]),    0);
      chk("rst_err",   d, int'(err[d]),   0);
      chk("rst_tries", d, get_tries(d),   0);
    end

    // Basic accept, held for 5 cycles before ack.
    rq = '{16'h0005};
    go(0, 6, mk(5, 0, 0, 0, 2));
    finish_ack(0, 5);

    // Two rejections (7 and 6 out of range) then 3.
    rq = '{16'h0007, 16'h0006, 16'h0003};
    go(0, 6, mk(3, 0, 0, 2, 4));
    finish_ack(0, 0);

    // 3 repeats the last result, so it is rejected; 4 accepted.
    rq = '{16'h0003, 16'h0004};
    go(0, 6, mk(4, 0, 0, 1, 3));
    finish_ack(0, 1);

    // Zero range takes the error path in one edge.
    rq = '{};
    go(0, 0, mk(0, 0, 1, 0, 1));
    finish_ack(0, 0);

    // Range 1 after the error: mask 0, candidate 0.
    rq = '{16'h1234};
    go(0, 1, mk(0, 0, 0, 0, 2));
    finish_ack(0, 0);

    // Full-width mask.
    rq = '{16'hABFE};
    go(0, 255, mk(254, 0, 0, 0, 2));
    finish_ack(0, 2);

    // Reset while rejecting.
    @(posedge clk); #1;
    req[0] = 1'b1; range_i[0] = 8'd6; rand_num[0] = 16'h0007;
    @(posedge clk); #1;
    req[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    chk("midrst_valid", 0, int'(valid[0]), 0);
    chk("midrst_busy",  0, int'(busy[0]),  0);
    chk("midrst_tries", 0, get_tries(0),   0);
    rq = '{16'h0002};
    go(0, 6, mk(2, 0, 0, 0, 2));
    finish_ack(0, 0);

    // NO_REPEAT=0: the same value twice in a row is accepted.
    rq = '{16'h0003};
    go(1, 6, mk(3, 0, 0, 0, 2));
    finish_ack(1, 0);
    rq = '{16'h0003};
    go(1, 6, mk(3, 0, 0, 0, 2));
    finish_ack(1, 0);

    // MAX_TRIES=4: cand 7 every edge, fold to 1, then bumped to 2.
    rq = '{16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF};
    go(2, 6, mk(1, 1, 0, 4, 5));
    finish_ack(2, 0);
    go(2, 6, mk(2, 1, 0, 4, 5));
    finish_ack(2, 0);

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("queue_drained", d, q[d].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rand_range_sampler.md
Name: rand_range_sampler

Overview:
- Downstream consumer of the 16-bit LFSR pseudo-random generator output `rand_num`.
- Converts the free-running 16-bit stream into a uniformly distributed value in [0, range_i) on request, using mask-and-reject sampling.
- Optionally forbids two consecutive identical results.
- Delivers each result over a valid/ack handshake to game/control logic.

Parameters:
- OUT_W, 8, width of range_i and value_o.
- MAX_TRIES, 16, rejections allowed before the fallback path is used. Must be ≥1.
- NO_REPEAT, 1, when 1 a result equal to the previously acknowledged result is rejected.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- rand_num  in  16  LFSR output; upstream advances it every clk
- req  in  1  request a new sample; sampled only in IDLE
- range_i  in  OUT_W  exclusive upper bound; latched on accepted req
- ack  in  1  consumer accepts value_o; sampled only in DONE
- value_o  out  OUT_W  sampled result, stable while valid_o=1
- valid_o  out  1  result available
- busy_o  out  1  high in SAMPLE and DONE
- fallback_o  out  1  result came from the fallback path
- err_o  out  1  range_i was 0
- tries_o  out  $clog2(MAX_TRIES+1)  rejections for the current result

Behaviour:
- Reset (rst=1 at a clk edge, any state): state=IDLE; value_o, valid_o, busy_o, fallback_o, err_o, tries_o = 0; internal last_valid=0, last_value=0, range_q=0, mask_q=0.
- FSM states: IDLE, SAMPLE, DONE.
- IDLE, req=0: remain in IDLE.
- IDLE, req=1, range_i=0: go to DONE with value_o=0, err_o=1, fallback_o=0, tries_o=0.
- IDLE, req=1, range_i≥1:
  - range_q <= range_i.
  - mask_q <= smallest 2^k−1 ≥ range_i−1 (range 1 → mask 0).
  - tries_o <= 0; fallback_o <= 0; err_o <= 0.
  - Go to SAMPLE.
- SAMPLE, each edge:
  - cand = rand_num[OUT_W-1:0] & mask_q.
  - ok = (cand < range_q) && !(NO_REPEAT && last_valid && range_q>1 && cand==last_value).
  - If ok: value_o<=cand, go to DONE.
  - Else if tries_o == MAX_TRIES−1: fallback. f = (cand ≥ range_q) ? cand−range_q : cand. If NO_REPEAT && last_valid && range_q>1 && f==last_value, then f = (f==range_q−1) ? 0 : f+1. value_o<=f, fallback_o<=1, tries_o<=MAX_TRIES, go to DONE.
  - Else: tries_o<=tries_o+1, stay in SAMPLE.
- Arithmetic: cand < 2·range_q always holds, so f is always in range. No wide modulo or divider is allowed.
- DONE:
  - valid_o=1; value_o, fallback_o, err_o, tries_o are held.
  - On ack=1: last_value<=value_o, last_valid<=!err_o, go to IDLE.
  - req is ignored while in SAMPLE or DONE. A req coincident with ack is dropped; the consumer re-asserts it in IDLE.
- Latency: req edge → SAMPLE; result valid after the next edge if the first candidate is accepted (2 edges min). Max latency is MAX_TRIES+1 edges. The err path takes 1 edge.
- valid_o and busy_o are registered state decodes, with no combinational path from inputs.
- rand_num is not registered internally. The value present at each SAMPLE edge is the candidate.

Test Plan (bench drives rand_num directly; OUT_W=8, MAX_TRIES=16, NO_REPEAT=1 unless noted):
- Basic: reset, range_i=6, req for 1 cycle, rand_num=16'h0005 → mask 7, after 2nd edge valid_o=1, value_o=5, tries_o=0, fallback_o=0. Hold ack=0 for 5 cycles → value_o stays 5; ack → IDLE, busy_o=0.
- Rejection: range_i=6, rand_num sequence 16'h0007, 16'h0006, 16'h0003 on successive SAMPLE edges → value_o=3, tries_o=2, valid_o high on the 4th edge after req.
- No-repeat: after acking 3, req range 6 with rand_num 16'h0003 then 16'h0004 → value_o=4, tries_o=1. Repeat with NO_REPEAT=0 → value_o=3, tries_o=0.
- Fallback (MAX_TRIES=4): range_i=6, rand_num held 16'h00FF (cand=7) → after 4 SAMPLE edges value_o=1, fallback_o=1, tries_o=4. With last_value=1 → value_o=2.
- Edge ranges:
  - range_i=0 → next edge valid_o=1, err_o=1, value_o=0.
  - range_i=1 with last_value=0 → value_o=0, tries_o=0.
  - range_i=255, rand_num=16'hABFE → value_o=254.
- Reset mid-operation: rst=1 while in SAMPLE (rand_num held 16'h0007, range 6) → next edge valid_o=0, busy_o=0, tries_o=0. A following req with rand_num 16'h0002 → value_o=2; a repeat check does not fire since last_valid was cleared.
